// File: rtl/tpu_pkg.sv
// Shared definitions for the processing-element tiles.
//   pe_mode_e    : PE dataflow mode (weight-stationary pass-through or
//                  output-stationary local accumulation).
//   swap_state_e : state of the shadow-to-active weight swap controller.
package tpu_pkg;

  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-add for one PE.
//   i_a, i_w   : signed operands (COMPUTE_DATA_WIDTH)
//   i_addend   : signed addend (ACCUMULATOR_DATA_WIDTH)
//   o_result   : fix(i_addend + i_a*i_w), clamped or wrapped per SATURATE
//   o_overflow : the unfixed sum lies outside the accumulator range
module pe_mac #(
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int SATURATE               = 1
) (
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     i_a,
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     i_w,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] i_addend,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] o_result,
  output logic                                     o_overflow
);

  localparam int CDW = COMPUTE_DATA_WIDTH;
  localparam int ADW = ACCUMULATOR_DATA_WIDTH;

  logic signed [2*CDW-1:0] w_prod;
  logic signed [ADW:0]     w_prod_ext;
  logic signed [ADW:0]     w_addend_ext;
  logic signed [ADW:0]     w_sum;

  // One guard bit above the accumulator width: the sum of an in-range
  // addend and a 2*CDW product can never exceed ADW+1 bits.
  function automatic logic signed [ADW-1:0] fix(input logic signed [ADW:0] s);
    logic signed [ADW-1:0] v;
    v = s[ADW-1:0];
    if ((SATURATE != 0) && (s[ADW] != s[ADW-1]))
      v = s[ADW] ? {1'b1, {(ADW-1){1'b0}}} : {1'b0, {(ADW-1){1'b1}}};
    return v;
  endfunction

  assign w_prod       = i_a * i_w;
  assign w_prod_ext   = {{(ADW+1-2*CDW){w_prod[2*CDW-1]}}, w_prod};
  assign w_addend_ext = {i_addend[ADW-1], i_addend};
  assign w_sum        = w_addend_ext + w_prod_ext;

  assign o_result   = fix(w_sum);
  assign o_overflow = w_sum[ADW] ^ w_sum[ADW-1];

endmodule

// File: rtl/pe_dbuf.sv
// Systolic processing element with a double-buffered (shadow/active) weight.
//   clk, rst (sync, active-low)
//   mode            : 0 weight-stationary pass-through, 1 output-stationary
//   clear           : zero accumulator and overflow (with data_valid in
//                     mode 1, starts a new tile from the current product)
//   data_valid/data_in       : activation stream
//   weight_valid/weights_in  : shadow-weight load stream
//   swap            : promote shadow to active (deferred during a burst)
//   partial_sum_in  : upstream psum used in mode 0
//   activation_out/valid_out        : registered activation forward
//   weight_out/weight_valid_out     : registered weight daisy-chain
//   psum_out        : mode 0 result, or the accumulator in mode 1
//   swap_pending    : a swap is waiting for the burst to end
//   overflow        : sticky overflow flag
module pe_dbuf
  import tpu_pkg::*;
#(
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int SATURATE               = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     mode,
  input  logic                                     clear,
  input  logic                                     data_valid,
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     data_in,
  input  logic                                     weight_valid,
  input  logic signed [COMPUTE_DATA_WIDTH-1:0]     weights_in,
  input  logic                                     swap,
  input  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] partial_sum_in,
  output logic signed [COMPUTE_DATA_WIDTH-1:0]     activation_out,
  output logic                                     valid_out,
  output logic signed [COMPUTE_DATA_WIDTH-1:0]     weight_out,
  output logic                                     weight_valid_out,
  output logic signed [ACCUMULATOR_DATA_WIDTH-1:0] psum_out,
  output logic                                     swap_pending,
  output logic                                     overflow
);

  localparam int CDW = COMPUTE_DATA_WIDTH;
  localparam int ADW = ACCUMULATOR_DATA_WIDTH;

  pe_mode_e    w_mode;
  swap_state_e r_state;
  swap_state_e w_state_nxt;
  logic        w_do_swap;

  logic signed [CDW-1:0] r_shadow;
  logic signed [CDW-1:0] r_active;
  logic signed [ADW-1:0] r_acc;
  logic signed [ADW-1:0] r_psum;
  logic signed [CDW-1:0] r_act_out;
  logic                  r_valid_out;
  logic signed [CDW-1:0] r_wgt_out;
  logic                  r_wgt_valid_out;
  logic                  r_overflow;

  logic signed [ADW-1:0] w_addend;
  logic signed [ADW-1:0] w_fix;
  logic                  w_ovf;

  assign w_mode = pe_mode_e'(mode);

  // A clear in mode 1 restarts the tile, so the product is added to zero
  // rather than to the stale accumulator.
  assign w_addend = (w_mode == PE_MODE_OS) ? (clear ? '0 : r_acc) : partial_sum_in;

  pe_mac #(
    .COMPUTE_DATA_WIDTH    (CDW),
    .ACCUMULATOR_DATA_WIDTH(ADW),
    .SATURATE              (SATURATE)
  ) u_mac (
    .i_a       (data_in),
    .i_w       (r_active),
    .i_addend  (w_addend),
    .o_result  (w_fix),
    .o_overflow(w_ovf)
  );

  // Swap controller: the active weight is never changed while activations
  // are streaming, so a request during a burst waits for the first idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_do_swap   = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (swap) begin
          if (data_valid) w_state_nxt = SWAP_PENDING;
          else            w_do_swap   = 1'b1;
        end
      end
      SWAP_PENDING: begin
        if (!data_valid) begin
          w_do_swap   = 1'b1;
          w_state_nxt = SWAP_IDLE;
        end
      end
      default: w_state_nxt = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= SWAP_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow        <= '0;
      r_active        <= '0;
      r_acc           <= '0;
      r_psum          <= '0;
      r_act_out       <= '0;
      r_valid_out     <= 1'b0;
      r_wgt_out       <= '0;
      r_wgt_valid_out <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_act_out       <= data_in;
      r_valid_out     <= data_valid;
      r_wgt_out       <= weights_in;
      r_wgt_valid_out <= weight_valid;

      // Same-edge swap and load: active takes the pre-write shadow value.
      if (weight_valid) r_shadow <= weights_in;
      if (w_do_swap)    r_active <= r_shadow;

      if (data_valid) begin
        r_psum <= w_fix;
        if (w_mode == PE_MODE_OS) r_acc <= w_fix;
        else if (clear)           r_acc <= '0;
      end else if (clear) begin
        r_acc <= '0;
        if (w_mode == PE_MODE_OS) r_psum <= '0;
      end

      r_overflow <= (r_overflow & ~clear) | (data_valid & w_ovf);
    end
  end

  assign activation_out   = r_act_out;
  assign valid_out        = r_valid_out;
  assign weight_out       = r_wgt_out;
  assign weight_valid_out = r_wgt_valid_out;
  assign psum_out         = r_psum;
  assign swap_pending     = (r_state == SWAP_PENDING);
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_pe_dbuf.sv
module tb_pe_dbuf;

  localparam int CDW = 4;
  localparam int ADW = 8;

  logic clk = 1'b0;
  logic rst, mode, clear, dv, wv, swap;
  logic signed [CDW-1:0] din, win;
  logic signed [ADW-1:0] psin;

  // Saturating instance (_s) and wrapping instance (_w) share all inputs.
  logic signed [CDW-1:0] aout_s, wout_s, aout_w, wout_w;
  logic                  vout_s, wvout_s, pend_s, ovf_s;
  logic                  vout_w, wvout_w, pend_w, ovf_w;
  logic signed [ADW-1:0] psum_s, psum_w;

  int checks = 0;
  int errors = 0;

  // Reference model: behavioural state in plain integers (index 0 = saturating).
  int               m_shadow, m_active;
  bit               m_pend;
  int               m_acc [2];
  int               m_psum[2];
  bit               m_ovf [2];
  logic signed [CDW-1:0] m_aout, m_wout;
  bit               m_vout, m_wvout;

  always #5 clk = ~clk;

  pe_dbuf #(.COMPUTE_DATA_WIDTH(CDW), .ACCUMULATOR_DATA_WIDTH(ADW), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .data_valid(dv), .data_in(din), .weight_valid(wv), .weights_in(win),
    .swap(swap), .partial_sum_in(psin),
    .activation_out(aout_s), .valid_out(vout_s), .weight_out(wout_s),
    .weight_valid_out(wvout_s), .psum_out(psum_s), .swap_pending(pend_s),
    .overflow(ovf_s)
  );

  pe_dbuf #(.COMPUTE_DATA_WIDTH(CDW), .ACCUMULATOR_DATA_WIDTH(ADW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .mode(mode), .clear(clear),
    .data_valid(dv), .data_in(din), .weight_valid(wv), .weights_in(win),
    .swap(swap), .partial_sum_in(psin),
    .activation_out(aout_w), .valid_out(vout_w), .weight_out(wout_w),
    .weight_valid_out(wvout_w), .psum_out(psum_w), .swap_pending(pend_w),
    .overflow(ovf_w)
  );

  function automatic int fixv(int sum, int s);
    logic signed [ADW-1:0] t;
    if (s == 0) begin
      if (sum > 127)  return 127;
      if (sum < -128) return -128;
      return sum;
    end
    t = sum[ADW-1:0];
    return int'(t);
  endfunction

  task automatic model_step();
    int d, p, sum, base, old_shadow;
    if (!rst) begin
      m_shadow = 0; m_active = 0; m_pend = 0;
      for (int s = 0; s < 2; s++) begin m_acc[s] = 0; m_psum[s] = 0; m_ovf[s] = 0; end
      m_aout = '0; m_wout = '0; m_vout = 0; m_wvout = 0;
    end else begin
      d = din;
      p = d * m_active;
      for (int s = 0; s < 2; s++) begin
        if (clear) begin m_acc[s] = 0; m_ovf[s] = 0; end
        if (dv) begin
          base = mode ? m_acc[s] : int'(psin);
          sum  = base + p;
          if (sum > 127 || sum < -128) m_ovf[s] = 1;
          if (mode) begin m_acc[s] = fixv(sum, s); m_psum[s] = m_acc[s]; end
          else m_psum[s] = fixv(sum, s);
        end else if (clear && mode) begin
          m_psum[s] = 0;
        end
      end
      old_shadow = m_shadow;
      if (!m_pend) begin
        if (swap) begin
          if (dv) m_pend = 1;
          else    m_active = old_shadow;
        end
      end else if (!dv) begin
        m_active = old_shadow;
        m_pend = 0;
      end
      if (wv) m_shadow = int'(win);
      m_aout = din; m_vout = dv; m_wout = win; m_wvout = wv;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; clear = 1'b0; dv = 1'b0; wv = 1'b0; swap = 1'b0;
    din = '0; win = '0; psin = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 1'b1; clear = 1'b0; dv = 1'b1; din = 4'sd5;
    wv = 1'b1; win = 4'sd3; swap = 1'b1; psin = 8'sd20;
    cycle();
    checks++;
    if ({aout_s, vout_s, wout_s, wvout_s, psum_s, pend_s, ovf_s} !== '0) begin
      errors++;
      $display("FAIL reset_sat: outputs=%h expected 0", {aout_s, vout_s, wout_s, wvout_s, psum_s, pend_s, ovf_s});
    end
    checks++;
    if ({aout_w, vout_w, wout_w, wvout_w, psum_w, pend_w, ovf_w} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: outputs=%h expected 0", {aout_w, vout_w, wout_w, wvout_w, psum_w, pend_w, ovf_w});
    end
    idle();
  endtask

  task automatic test_saturate();
    int exp_s[3] = '{49, 98, 127};
    int exp_w[3] = '{49, 98, -109};
    idle(); wv = 1'b1; win = 4'sd7; cycle();
    idle(); swap = 1'b1; cycle();
    idle(); mode = 1'b1; clear = 1'b1; cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1; din = 4'sd7; cycle();
      checks++;
      if (psum_s !== exp_s[i]) begin
        errors++; $display("FAIL sat_acc[%0d]: got %0d expected %0d", i, psum_s, exp_s[i]);
      end
      checks++;
      if (psum_w !== exp_w[i]) begin
        errors++; $display("FAIL wrap_acc[%0d]: got %0d expected %0d", i, psum_w, exp_w[i]);
      end
    end
    checks++;
    if (ovf_s !== 1'b1 || ovf_w !== 1'b1) begin
      errors++; $display("FAIL overflow_set: sat=%b wrap=%b expected 1 1", ovf_s, ovf_w);
    end
    idle(); clear = 1'b1; cycle();
    checks++;
    if (psum_s !== 0 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
      errors++; $display("FAIL clear: psum=%0d ovf_s=%b ovf_w=%b expected 0 0 0", psum_s, ovf_s, ovf_w);
    end
    idle();
  endtask

  task automatic test_ws_mode();
    idle(); wv = 1'b1; win = -4'sd8; cycle();
    idle(); swap = 1'b1; cycle();
    idle(); mode = 1'b0; dv = 1'b1; din = -4'sd8; psin = 8'sd10; cycle();
    checks++;
    if (psum_s !== 74 || psum_w !== 74) begin
      errors++; $display("FAIL ws_psum: sat=%0d wrap=%0d expected 74", psum_s, psum_w);
    end
    checks++;
    if (aout_s !== -4'sd8 || vout_s !== 1'b1) begin
      errors++; $display("FAIL ws_forward: act=%0d valid=%b expected -8 1", aout_s, vout_s);
    end
    idle(); mode = 1'b1; cycle();
    checks++;
    if (psum_s !== 74) begin
      errors++; $display("FAIL mode_change_hold: got %0d expected 74", psum_s);
    end
    dv = 1'b1; din = 4'sd1; cycle();
    checks++;
    if (psum_s !== -8) begin
      errors++; $display("FAIL os_after_ws: got %0d expected -8", psum_s);
    end
    idle();
  endtask

  task automatic test_swap_deferred();
    int pend_cycles = 0;
    idle(); mode = 1'b0; wv = 1'b1; win = 4'sd1; cycle();
    idle(); swap = 1'b1; cycle();
    idle(); wv = 1'b1; win = 4'sd2; cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1; din = 4'sd1; swap = (i < 2);
      cycle();
      if (pend_s === 1'b1) pend_cycles++;
      checks++;
      if (psum_s !== 1) begin
        errors++; $display("FAIL burst_old_weight[%0d]: got %0d expected 1", i, psum_s);
      end
    end
    checks++;
    if (pend_cycles != 3) begin
      errors++; $display("FAIL pending_len: got %0d cycles expected 3", pend_cycles);
    end
    idle(); wv = 1'b1; win = 4'sd3; cycle();
    checks++;
    if (pend_s !== 1'b0) begin
      errors++; $display("FAIL pending_release: got %b expected 0", pend_s);
    end
    for (int i = 0; i < 2; i++) begin
      idle(); dv = 1'b1; din = 4'sd1; cycle();
      checks++;
      if (psum_s !== 2 || pend_s !== 1'b0) begin
        errors++; $display("FAIL burst_new_weight[%0d]: psum=%0d pend=%b expected 2 0", i, psum_s, pend_s);
      end
    end
    idle();
  endtask

  task automatic test_swap_same_edge();
    idle(); mode = 1'b0; wv = 1'b1; win = 4'sd5; cycle();
    idle(); swap = 1'b1; wv = 1'b1; win = 4'sd3; cycle();
    idle(); dv = 1'b1; din = 4'sd1; cycle();
    checks++;
    if (psum_s !== 5) begin
      errors++; $display("FAIL same_edge_active: got %0d expected 5", psum_s);
    end
    idle(); swap = 1'b1; cycle();
    idle(); dv = 1'b1; din = 4'sd1; cycle();
    checks++;
    if (psum_s !== 3) begin
      errors++; $display("FAIL same_edge_shadow: got %0d expected 3", psum_s);
    end
    idle();
  endtask

  task automatic test_reset_pending();
    idle(); wv = 1'b1; win = 4'sd5; cycle();
    idle(); swap = 1'b1; cycle();
    idle(); mode = 1'b1; clear = 1'b1; cycle();
    idle(); wv = 1'b1; win = 4'sd2; dv = 1'b1; din = 4'sd4; cycle();
    idle(); dv = 1'b1; din = 4'sd4; cycle();
    idle(); swap = 1'b1; dv = 1'b1; din = 4'sd0; cycle();
    checks++;
    if (psum_s !== 40 || pend_s !== 1'b1) begin
      errors++; $display("FAIL pre_reset: psum=%0d pend=%b expected 40 1", psum_s, pend_s);
    end
    idle(); rst = 1'b0; dv = 1'b1; din = 4'sd3; cycle();
    checks++;
    if ({aout_s, vout_s, wout_s, wvout_s, psum_s, pend_s, ovf_s} !== '0) begin
      errors++;
      $display("FAIL reset_mid_pending: outputs=%h expected 0", {aout_s, vout_s, wout_s, wvout_s, psum_s, pend_s, ovf_s});
    end
    idle(); dv = 1'b1; din = 4'sd3; cycle();
    checks++;
    if (psum_s !== 0) begin
      errors++; $display("FAIL post_reset_state: got %0d expected 0", psum_s);
    end
    idle();
  endtask

  task automatic test_random();
    idle(); rst = 1'b0; cycle();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) >= 2);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      clear = ($urandom_range(0, 19) == 0);
      dv    = ($urandom_range(0, 9) < 6);
      wv    = ($urandom_range(0, 9) < 3);
      swap  = ($urandom_range(0, 9) < 2);
      din   = CDW'($urandom);
      win   = CDW'($urandom);
      psin  = ADW'($urandom);
      cycle();
      checks++;
      if (aout_s !== m_aout || vout_s !== m_vout || wout_s !== m_wout || wvout_s !== m_wvout) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: act=%0d/%0d vld=%b/%b w=%0d/%0d wv=%b/%b (got/expected)",
                 n, aout_s, m_aout, vout_s, m_vout, wout_s, m_wout, wvout_s, m_wvout);
      end
      checks++;
      if (psum_s !== m_psum[0] || ovf_s !== m_ovf[0] || pend_s !== m_pend) begin
        errors++;
        $display("FAIL rand_sat[%0d]: psum=%0d/%0d ovf=%b/%b pend=%b/%b (got/expected)",
                 n, psum_s, m_psum[0], ovf_s, m_ovf[0], pend_s, m_pend);
      end
      checks++;
      if (psum_w !== m_psum[1] || ovf_w !== m_ovf[1] || pend_w !== m_pend) begin
        errors++;
        $display("FAIL rand_wrap[%0d]: psum=%0d/%0d ovf=%b/%b pend=%b/%b (got/expected)",
                 n, psum_w, m_psum[1], ovf_w, m_ovf[1], pend_w, m_pend);
      end
    end
    idle();
  endtask

  initial begin
    mode = 1'b0;
    idle();
    test_reset();
    test_saturate();
    test_ws_mode();
    test_swap_deferred();
    test_swap_same_edge();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
